// File: rtl/four_to_one_rr_mux.sv
// Round-robin 4:1 valid/ready merge onto one registered output beat tagged with its source index.
// Optional even-parity output out_par is enabled by defining RR_MUX_PARITY_EN.
module four_to_one_rr_mux #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [3:0]              in_valid,
  output logic [3:0]              in_ready,
  input  logic [4*DATA_WIDTH-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic [1:0]              out_sel
`ifdef RR_MUX_PARITY_EN
  ,
  output logic                    out_par
`endif
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t                          state_q, state_d;
  logic   [1:0]                    ptr_q;
  logic   [1:0]                    gnt;
  logic   [1:0]                    idx;
  logic                            any_vld;
  logic                            load_ok;
  logic                            take;
  logic   [3:0][DATA_WIDTH-1:0]    lane_data;

  assign lane_data = in_data;
  assign any_vld   = |in_valid;
  assign out_valid = (state_q == FULL);
  assign load_ok   = ~out_valid | out_ready;
  assign take      = load_ok & any_vld;

  // Walk from ptr+3 down to ptr so the nearest requester to ptr is written last and wins.
  always_comb begin
    gnt = ptr_q;
    idx = ptr_q;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr_q + 2'(k);
      if (in_valid[idx]) gnt = idx;
    end
  end

  // Ready depends only on valids and the grant, never on data; forced low during reset.
  for (genvar i = 0; i < 4; i++) begin : g_rdy
    assign in_ready[i] = rst_n & take & (gnt == 2'(i));
  end

  always_comb begin
    state_d = state_q;
    if (load_ok) state_d = any_vld ? FULL : EMPTY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
      out_sel  <= '0;
      ptr_q    <= '0;
    end else if (take) begin
      out_data <= lane_data[gnt];
      out_sel  <= gnt;
      ptr_q    <= gnt + 2'd1;
    end
  end

`ifdef RR_MUX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    out_par <= 1'b0;
    else if (take) out_par <= ^lane_data[gnt];
  end
`endif

endmodule

// File: tb/tb_four_to_one_rr_mux.sv
// Directed bench for four_to_one_rr_mux: reset, single channel, rotation, backpressure, wrap/drain, parity.
module tb_four_to_one_rr_mux;

  logic        clk;
  logic        rst_n;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_sel;
`ifdef RR_MUX_PARITY_EN
  logic        out_par;
`endif

  int n_run  = 0;
  int n_fail = 0;

  four_to_one_rr_mux #(.DATA_WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_sel  (out_sel)
`ifdef RR_MUX_PARITY_EN
    ,
    .out_par  (out_par)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle, so checks and drives sit away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b0;
    #12;
    // reset state
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data",  32'(out_data),  32'd0);
    chk("rst_sel",   32'(out_sel),   32'd0);
    in_valid = 4'b1111;
    #1;
    chk("rst_ready", 32'(in_ready),  32'd0);
    in_valid = '0;
    step();
    rst_n = 1'b1;

    // single channel 2
    in_valid = 4'b0100; in_data[16 +: 8] = 8'h3C; out_ready = 1'b1;
    #1;
    chk("single_ready", 32'(in_ready), 32'b0100);
    step();
    chk("single_valid", 32'(out_valid), 32'd1);
    chk("single_data",  32'(out_data),  32'h3C);
    chk("single_sel",   32'(out_sel),   32'd2);

    // load A5 (ptr=3 wraps to ch0), then async reset mid-FULL
    in_valid = 4'b0001; in_data[0 +: 8] = 8'hA5;
    step();
    chk("a5_data", 32'(out_data), 32'hA5);
    out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_data",  32'(out_data),  32'd0);
    chk("arst_sel",   32'(out_sel),   32'd0);
    chk("arst_ready", 32'(in_ready),  32'd0);
    step();
    rst_n = 1'b1;

    // round robin from reset, all channels valid
    in_valid = 4'b1111; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) in_data[i*8 +: 8] = 8'(8'h10 + i);
    for (int k = 0; k < 6; k++) begin
      step();
      chk("rr_valid", 32'(out_valid), 32'd1);
      chk("rr_sel",   32'(out_sel),   32'(k % 4));
      chk("rr_data",  32'(out_data),  32'(8'h10 + (k % 4)));
    end

    // backpressure while FULL with sel=1
    out_ready = 1'b0;
    #1;
    chk("bp_ready0", 32'(in_ready), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_sel",   32'(out_sel),   32'd1);
      chk("bp_data",  32'(out_data),  32'h11);
      chk("bp_ready", 32'(in_ready),  32'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_rel_ready", 32'(in_ready), 32'b0100);
    step();
    chk("bp_rel_sel",  32'(out_sel),  32'd2);
    chk("bp_rel_data", 32'(out_data), 32'h12);

    // sparse wrap from ptr=1, then drain
    do_reset();
    in_valid = 4'b0001; in_data[0 +: 8] = 8'h44;
    step();
    chk("sp_first", 32'(out_sel), 32'd0);
    in_data[0 +: 8] = 8'h55;
    #1;
    chk("sp_ready", 32'(in_ready), 32'b0001);
    step();
    chk("sp_sel",  32'(out_sel),  32'd0);
    chk("sp_data", 32'(out_data), 32'h55);
    in_valid = '0;
    step();
    chk("drain_valid", 32'(out_valid), 32'd0);
    chk("drain_data",  32'(out_data),  32'h55);
    chk("drain_sel",   32'(out_sel),   32'd0);
    in_valid = 4'b1111;
    step();
    chk("drain_ptr", 32'(out_sel), 32'd1);

`ifdef RR_MUX_PARITY_EN
    do_reset();
    chk("par_rst", 32'(out_par), 32'd0);
    in_valid = 4'b1000; in_data[24 +: 8] = 8'h07;
    step();
    chk("par_sel3", 32'(out_sel), 32'd3);
    chk("par_07",   32'(out_par), 32'd1);
    in_valid = 4'b0001; in_data[0 +: 8] = 8'h03;
    step();
    chk("par_03",   32'(out_par), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
